// File: rtl/uart_tx_fifo.sv
// First-word-fall-through byte FIFO feeding the UART transmitter.
// The head word is held stable until the transmitter pops it with tx_done_tick.
module uart_tx_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int AF_THRESH  = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic                  flush,
  input  logic                  clr_err,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] FULL_CNT = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AF_CNT   = (ADDR_WIDTH+1)'(AF_THRESH);
  localparam logic [ADDR_WIDTH:0] CNT_ONE  = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   count_q;
  logic                  wr_acc;
  logic                  rd_acc;
  logic                  ovf_ev;
  logic                  udf_ev;

  assign empty       = (count_q == '0);
  assign full        = (count_q == FULL_CNT);
  assign almost_full = (count_q >= AF_CNT);
  assign count       = count_q;
  assign rd_data     = mem[rd_ptr];

  // A pop frees a slot in the same cycle, so a write into a full FIFO is
  // still accepted when rd_en is high; a pop of an empty FIFO never is.
  assign wr_acc = wr_en & (~full | rd_en);
  assign rd_acc = rd_en & ~empty;
  assign ovf_ev = wr_en & full & ~rd_en;
  assign udf_ev = rd_en & empty;

  always_ff @(posedge clk) begin
    if (!rst && !flush && wr_acc) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count_q   <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (flush) begin
        wr_ptr  <= '0;
        rd_ptr  <= '0;
        count_q <= '0;
      end else begin
        if (wr_acc) wr_ptr <= wr_ptr + PTR_ONE;
        if (rd_acc) rd_ptr <= rd_ptr + PTR_ONE;
        case ({wr_acc, rd_acc})
          2'b10:   count_q <= count_q + CNT_ONE;
          2'b01:   count_q <= count_q - CNT_ONE;
          default: count_q <= count_q;
        endcase
      end
      overflow  <= ovf_ev | (overflow  & ~clr_err);
      underflow <= udf_ev | (underflow & ~clr_err);
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: queue-based reference model, directed
// scenarios, a behavioural 8N1 transmitter and a randomized phase.
module tb_uart_tx_fifo;

  localparam int DEPTH = 16;
  localparam int AF    = 12;

  logic       clk = 1'b0;
  logic       rst, wr_en, rd_en, flush, clr_err;
  logic [7:0] wr_data, rd_data;
  logic       empty, full, almost_full, overflow, underflow;
  logic [4:0] count;

  int tests = 0;
  int fails = 0;

  // reference model state
  logic [7:0] mq[$];
  logic [7:0] sbq[$];
  bit         m_valid = 0, m_ov = 0, m_un = 0;

  // expected outputs for the cycle currently being driven
  bit         cur_valid = 0, cur_gate = 0, cur_ov, cur_un;
  int         cur_count;
  logic [7:0] cur_head;

  uart_tx_fifo #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .AF_THRESH(AF)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .flush(flush), .clr_err(clr_err), .rd_data(rd_data), .empty(empty),
    .full(full), .almost_full(almost_full), .count(count),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs and advance the reference model across the edge.
  task automatic step(input bit w, input logic [7:0] d, input bit r,
                      input bit f, input bit c, input bit rs);
    bit ov_ev, un_ev;
    wr_en = w; wr_data = d; rd_en = r; flush = f; clr_err = c; rst = rs;
    cur_valid = m_valid;
    cur_gate  = !rs && !f;
    cur_count = mq.size();
    cur_ov    = m_ov;
    cur_un    = m_un;
    cur_head  = (mq.size() > 0) ? mq[0] : 8'h00;
    if (rs) begin
      mq.delete();
      m_ov = 0; m_un = 0; m_valid = 1;
    end else begin
      ov_ev = w && (mq.size() == DEPTH) && !r;
      un_ev = r && (mq.size() == 0);
      if (f) mq.delete();
      else begin
        bit do_push;
        do_push = w && ((mq.size() < DEPTH) || r);
        if (r && mq.size() > 0) sbq.push_back(mq.pop_front());
        if (do_push) mq.push_back(d);
      end
      m_ov = ov_ev || (m_ov && !c);
      m_un = un_ev || (m_un && !c);
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 8'h00, 0, 0, 0, 0);
  endtask

  // Monitor: flags every cycle, popped data whenever the DUT presents a pop.
  always @(negedge clk) begin
    if (cur_valid) begin
      chk("count", 32'(count), 32'(cur_count));
      chk("empty", 32'(empty), 32'(cur_count == 0));
      chk("full", 32'(full), 32'(cur_count == DEPTH));
      chk("almost_full", 32'(almost_full), 32'(cur_count >= AF));
      chk("overflow", 32'(overflow), 32'(cur_ov));
      chk("underflow", 32'(underflow), 32'(cur_un));
      if (cur_count > 0) chk("head", 32'(rd_data), 32'(cur_head));
      if (cur_gate && rd_en === 1'b1 && empty === 1'b0) begin
        if (sbq.size() == 0) chk("pop_unexpected", 32'(rd_data), 32'hFFFF_FFFF);
        else chk("pop_data", 32'(rd_data), 32'(sbq.pop_front()));
      end
    end
  end

  // Behavioural 8N1 transmitter, one bit = 16 cycles, popping on tx_done_tick.
  task automatic tx_run(input logic [7:0] e0, input logic [7:0] e1);
    logic [7:0] exp_b[2];
    logic [7:0] din, rx;
    bit line;
    int frames = 0, extra = 0, guard = 0;
    exp_b[0] = e0; exp_b[1] = e1;
    rx = 8'h00;
    while (frames < 2 && guard < 200) begin
      if (empty === 1'b0) begin
        if (frames > 0) chk("tx_gap", 32'(extra), 32'd0);
        din = rd_data;
        idle(1);
        for (int b = 0; b < 10; b++) begin
          for (int s = 0; s < 16; s++) begin
            line = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : din[b-1];
            if (s == 8 && b >= 1 && b <= 8) rx[b-1] = line;
            step(0, 8'h00, (b == 9 && s == 15), 0, 0, 0);
          end
        end
        chk("tx_frame", 32'(rx), 32'(exp_b[frames]));
        frames++;
        extra = 0;
      end else begin
        idle(1);
        extra++;
        guard++;
      end
    end
    chk("tx_frames_done", 32'(frames), 32'd2);
    chk("tx_empty_end", 32'(empty), 32'd1);
  endtask

  initial begin
    rst = 1; wr_en = 0; wr_data = 0; rd_en = 0; flush = 0; clr_err = 0;
    @(posedge clk); #1;

    // reset then underflow on an empty pop
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    idle(1);
    step(0, 0, 1, 0, 0, 0);
    idle(1);
    step(0, 0, 0, 0, 1, 0);

    // FWFT ordering
    step(1, 8'h41, 0, 0, 0, 0);
    step(1, 8'h42, 0, 0, 0, 0);
    step(1, 8'h43, 0, 0, 0, 0);
    idle(1);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0, 0);
    idle(1);

    // fill, overflow, drain, wrap
    for (int i = 0; i < 16; i++) step(1, 8'(i), 0, 0, 0, 0);
    step(1, 8'hFF, 0, 0, 0, 0);
    idle(1);
    for (int i = 0; i < 16; i++) step(0, 0, 1, 0, 0, 0);
    step(1, 8'hA5, 0, 0, 0, 0);
    idle(1);
    step(0, 0, 1, 0, 1, 0);

    // full + write + pop, then empty + write + pop
    for (int i = 0; i < 16; i++) step(1, 8'(8'h10 + i), 0, 0, 0, 0);
    step(1, 8'h77, 1, 0, 0, 0);
    idle(1);
    for (int i = 0; i < 16; i++) step(0, 0, 1, 0, 0, 0);
    step(1, 8'h5A, 1, 0, 0, 0);
    idle(1);
    step(0, 0, 1, 0, 1, 0);
    idle(1);

    // flush with a same-cycle write, clear errors, set-wins on clear
    for (int i = 0; i < 5; i++) step(1, 8'(8'hC0 + i), 0, 0, 0, 0);
    step(1, 8'hEE, 0, 1, 0, 0);
    idle(1);
    step(0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 16; i++) step(1, 8'(8'h20 + i), 0, 0, 0, 0);
    step(1, 8'h99, 0, 0, 1, 0);
    idle(1);
    step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 1, 0);

    // integration with the transmitter
    step(1, 8'h48, 0, 0, 0, 0);
    step(1, 8'h49, 0, 0, 0, 0);
    tx_run(8'h48, 8'h49);

    // randomized phase with varying write pressure
    for (int i = 0; i < 4000; i++) begin
      int wp;
      bit w, r, f, c, rs;
      wp = ((i / 400) % 2 == 0) ? 75 : 30;
      w  = ($urandom_range(0, 99) < wp);
      r  = ($urandom_range(0, 99) < 50);
      f  = ($urandom_range(0, 99) == 0);
      c  = ($urandom_range(0, 19) == 0);
      rs = ($urandom_range(0, 999) == 0);
      if (f) begin w = 0; r = 0; end
      step(w, 8'($urandom), r, f, c, rs);
    end
    idle(2);
    chk("scoreboard_drained", 32'(sbq.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
